// File: rtl/v850_fetch_if.sv
// Fetch-stage bus bundle: redirect input, instruction-memory req/ack port, decoder valid/ready port.
// No latency of its own; it only groups wires.
// Backpressure: imem_ack_i completes a request, inst_ready_i accepts an instruction.
// Ports (master = fetch stage):
//   redirect_i, redirect_pc_i            executer redirect and its target
//   imem_req_o, imem_addr_o              halfword read request and address
//   imem_ack_i, imem_rdata_i             request completion and read halfword
//   inst_valid_o, inst_ready_i           decoder handshake
//   inst_o, inst_pc_o, inst_len32_o      assembled instruction, its PC, its length
interface v850_fetch_if;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic [15:0] imem_rdata_i;
  logic        inst_valid_o;
  logic        inst_ready_i;
  logic [31:0] inst_o;
  logic [31:0] inst_pc_o;
  logic        inst_len32_o;

  modport master (
    input  redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
    output imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_len32_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, imem_ack_i, imem_rdata_i, inst_ready_i,
    input  imem_req_o, imem_addr_o, inst_valid_o, inst_o, inst_pc_o, inst_len32_o
  );
endinterface

// File: rtl/v850_fetch.sv
// V850 fetch stage: reads halfwords over req/ack into a prefetch queue, assembles 16/32-bit instructions.
// Latency: req rises the cycle after space frees; an instruction is valid the cycle after its last halfword is acked.
// Backpressure: decoder stalls via inst_ready_i; a full queue holds imem_req_o low until a pop.
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   bus        v850_fetch_if.master (redirect, imem req/ack, decoder valid/ready)
module v850_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 4
) (
  input logic          clk,
  input logic          rst,
  v850_fetch_if.master bus
);
  localparam int             PW       = $clog2(QDEPTH);
  localparam int             CW       = PW + 1;
  localparam logic [CW-1:0]  QFULL    = CW'(QDEPTH);
  localparam logic [25:0]    RST_PC26 = {RESET_PC[25:1], 1'b0};

  // Prefetch queue: circular buffer addressed by head, tail = head + count.
  logic [15:0]   q [QDEPTH];
  logic [PW-1:0] head;
  logic [CW-1:0] count;
  logic [25:0]   fpc, dpc, addr;
  logic          req, discard;

  logic [15:0]   hw0, hw1;
  logic          len32, valid, pop, push, pending;
  logic [CW-1:0] need, pop_n, count_next;
  logic          discard_next, req_next;
  logic [25:0]   fpc_next, dpc_next, target;
  logic [PW-1:0] tail;

  // Bits outside the 26-bit halfword PC space are ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.redirect_pc_i[31:26], bus.redirect_pc_i[0]};

  always_comb begin
    hw0      = q[head];
    hw1      = q[head + PW'(1)];
    len32    = (hw0[10:9] == 2'b11);
    need     = len32 ? CW'(2) : CW'(1);
    // A 32-bit instruction waits until both halves are queued.
    valid    = !bus.redirect_i && (count >= need);
    pop      = valid && bus.inst_ready_i;
    pop_n    = pop ? need : '0;
    push     = req && bus.imem_ack_i && !discard && !bus.redirect_i;
    pending  = req && !bus.imem_ack_i;
    tail     = head + count[PW-1:0];
    target   = {bus.redirect_pc_i[25:1], 1'b0};

    if (bus.redirect_i) begin
      count_next   = '0;
      fpc_next     = target;
      dpc_next     = target;
      // An in-flight request cannot be cancelled; its data is dropped on arrival.
      discard_next = pending;
    end else begin
      count_next   = count + CW'(push) - pop_n;
      fpc_next     = push ? fpc + 26'd2 : fpc;
      dpc_next     = dpc + 26'(pop_n) + 26'(pop_n);
      discard_next = discard && pending;
    end

    // An unacked request stays up with its address; otherwise issue when space remains.
    req_next = pending || ((count_next < QFULL) && !discard_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc     <= RST_PC26;
      dpc     <= RST_PC26;
      addr    <= RST_PC26;
      head    <= '0;
      count   <= '0;
      req     <= 1'b0;
      discard <= 1'b0;
    end else begin
      fpc     <= fpc_next;
      dpc     <= dpc_next;
      count   <= count_next;
      req     <= req_next;
      discard <= discard_next;
      // Address is frozen while a request waits for its ack, even across a redirect.
      if (!pending) addr <= fpc_next;
      if (!bus.redirect_i) head <= head + pop_n[PW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[tail] <= bus.imem_rdata_i;
  end

  assign bus.imem_req_o   = req;
  assign bus.imem_addr_o  = {{6{addr[25]}}, addr};
  assign bus.inst_valid_o = valid;
  assign bus.inst_len32_o = len32;
  assign bus.inst_o       = len32 ? {hw1, hw0} : {16'h0000, hw0};
  assign bus.inst_pc_o    = {{6{dpc[25]}}, dpc};
endmodule

// File: tb/tb_v850_fetch.sv
// Self-checking bench for v850_fetch: memory responder with variable ack delay,
// a program-order reference model of the instruction stream, directed and random phases.
module tb_v850_fetch;
  localparam int QDEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  v850_fetch_if bus();

  v850_fetch #(.RESET_PC(32'h0000_0000), .QDEPTH(QDEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Instruction memory image: a few fixed locations, a 16-bit-only region, hash elsewhere.
  function automatic logic [15:0] memfn(input logic [25:0] a);
    logic [31:0] h;
    h = {6'b0, a} * 32'h9E37_79B1;
    if (a == 26'h000) return 16'h0001;
    if (a == 26'h100) return 16'h0660;
    if (a == 26'h102) return 16'h1234;
    if (a >= 26'h300 && a < 26'h320) return {8'h01, a[7:0]};
    return h[31:16] ^ h[15:0];
  endfunction

  function automatic logic [31:0] sx(input logic [25:0] a);
    return {{6{a[25]}}, a};
  endfunction

  // Reference model: next program PC to be decoded, halfwords fetched but not yet
  // consumed, whether an in-flight read is stale, and the expected next request address.
  logic [25:0] mpc;
  int          avail;
  bit          stale;
  bit          exp_new;
  logic [25:0] exp_addr;
  // Memory responder state.
  bit          prev_pending;
  logic [31:0] held_addr;
  int          age;
  int          dly;
  int          ack_dly;
  bit          last_redir;

  // One clock: drive inputs just after the edge, check outputs at the falling edge.
  // rmode: 0 none, 1 redirect, 2 redirect only if a request is waiting, 3 only on an ack cycle.
  task automatic cycle(input int rmode, input logic [31:0] tgt, input bit rdy);
    bit req, ack, is_new, redir;
    int need;
    logic [15:0] h0, h1;
    logic [31:0] exp_inst;
    @(posedge clk);
    #1;
    req    = bus.imem_req_o;
    is_new = req && !prev_pending;
    if (req && !is_new) check_eq("addr_hold", bus.imem_addr_o, held_addr);
    if (is_new) begin
      held_addr = bus.imem_addr_o;
      age = 0;
      dly = (ack_dly < 0) ? int'($urandom_range(2, 0)) : ack_dly;
      if (exp_new) begin
        check_eq("req_addr", bus.imem_addr_o, sx(exp_addr));
        exp_new = 1'b0;
      end
    end
    ack = req && (age >= dly);
    case (rmode)
      1:       redir = 1'b1;
      2:       redir = req && !ack;
      3:       redir = req && ack;
      default: redir = 1'b0;
    endcase
    bus.imem_ack_i    = ack;
    bus.imem_rdata_i  = ack ? memfn(bus.imem_addr_o[25:0]) : 16'($urandom);
    bus.redirect_i    = redir;
    bus.redirect_pc_i = tgt;
    bus.inst_ready_i  = rdy;
    prev_pending = req && !ack;
    if (req && !ack) age++;
    last_redir = redir;

    @(negedge clk);
    h0   = memfn(mpc);
    h1   = memfn(mpc + 26'd2);
    need = (h0[10:9] == 2'b11) ? 2 : 1;
    check_eq("valid", 32'(bus.inst_valid_o), 32'(!redir && (avail >= need)));
    if (bus.inst_valid_o) begin
      exp_inst = (need == 2) ? {h1, h0} : {16'h0000, h0};
      check_eq("inst_pc", bus.inst_pc_o, sx(mpc));
      check_eq("len32", 32'(bus.inst_len32_o), 32'(need == 2));
      check_eq("inst", bus.inst_o, exp_inst);
    end
    if (redir) begin
      mpc      = {tgt[25:1], 1'b0};
      avail    = 0;
      stale    = req && !ack;
      exp_new  = 1'b1;
      exp_addr = {tgt[25:1], 1'b0};
    end else begin
      if (req && ack) begin
        if (stale) stale = 1'b0;
        else avail++;
      end
      if (bus.inst_valid_o && rdy) begin
        avail -= need;
        mpc   += 26'(2 * need);
      end
    end
  endtask

  initial begin
    logic [31:0] t;
    bit fired;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = '0;
    bus.imem_ack_i    = 1'b0;
    bus.imem_rdata_i  = '0;
    bus.inst_ready_i  = 1'b0;
    rst = 1'b1;
    mpc = '0; avail = 0; stale = 1'b0; exp_new = 1'b1; exp_addr = '0;
    prev_pending = 1'b0; held_addr = '0; age = 0; dly = 0; ack_dly = 1; last_redir = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_req", 32'(bus.imem_req_o), 32'd0);
    check_eq("rst_valid", 32'(bus.inst_valid_o), 32'd0);
    check_eq("rst_pc", bus.inst_pc_o, 32'h0000_0000);
    @(posedge clk);
    #1 rst = 1'b0;

    // First instruction from reset PC, ack one cycle after each request.
    ack_dly = 1;
    repeat (10) cycle(0, '0, 1'b1);

    // 32-bit movea-type pair at 0x100.
    cycle(1, 32'h0000_0100, 1'b1);
    repeat (10) cycle(0, '0, 1'b1);

    // Fill the queue with the decoder stalled, then one 16-bit pop.
    ack_dly = 0;
    cycle(1, 32'h0000_0300, 1'b0);
    repeat (10) cycle(0, '0, 1'b0);
    check_eq("full_count", 32'(avail), 32'(QDEPTH));
    check_eq("full_req", 32'(bus.imem_req_o), 32'd0);
    cycle(0, '0, 1'b1);
    cycle(0, '0, 1'b0);
    check_eq("req_after_pop", 32'(bus.imem_req_o), 32'd1);
    repeat (6) cycle(0, '0, 1'b1);

    // Redirect while a slow request is outstanding.
    ack_dly = 3;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      cycle(2, 32'h0000_0201, 1'b1);
      fired = last_redir;
    end
    check_eq("redir_pending_fired", 32'(fired), 32'd1);
    repeat (16) cycle(0, '0, 1'b1);

    // Redirect into the negative half of the address space.
    ack_dly = -1;
    cycle(1, 32'h0200_0000, 1'b1);
    repeat (12) cycle(0, '0, 1'b1);

    // Redirect coinciding with an ack while the decoder is ready.
    ack_dly = 0;
    fired = 1'b0;
    for (int i = 0; i < 20 && !fired; i++) begin
      cycle(3, 32'h0000_0040, 1'b1);
      fired = last_redir;
    end
    check_eq("redir_ack_fired", 32'(fired), 32'd1);
    repeat (8) cycle(0, '0, 1'b1);

    // Random traffic: ack delays, stalls, redirects (some near the 2^26 wrap).
    ack_dly = -1;
    for (int i = 0; i < 3000; i++) begin
      t = $urandom;
      if ($urandom_range(3, 0) == 0) t = 32'h03FF_FFF0 | (t & 32'h0000_000F);
      cycle(($urandom_range(99, 0) < 3) ? 1 : 0, t,
            (((i / 64) % 4) == 3) ? ($urandom_range(7, 0) == 0) : ($urandom_range(3, 0) != 0));
    end

    ack_dly = 0;
    repeat (20) cycle(0, '0, 1'b1);
    check_eq("req_after_redirect", 32'(exp_new), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
